// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
//  Module : mem_port_arbiter_if
//  Desc   : Requester-side handshake bundle for one memory arbiter port.
//  Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mem_port_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module : mem_port_arbiter
//  Desc   : CPU-priority arbiter for the unified memory, with a starvation
//           counter that forces a loader grant after STARVE_LIMIT CPU wins.
//  Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_port_arbiter #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 32,
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 4
)(
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.slave  cpu,
   mem_port_arbiter_if.slave  ldr,
   output logic               cpu_stall,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_we,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic               busy
);

   localparam int                    c_STARVE_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);
   localparam logic [1:0]            c_WAIT_INIT = 2'(MEM_LAT - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ACCESS  = 2'd1;
   localparam logic [1:0] S_RD_WAIT = 2'd2;
   localparam logic [1:0] S_RESP    = 2'd3;

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic                  r_owner_ldr;
   logic                  r_we;
   logic [1:0]            r_wait_cnt;
   logic [c_STARVE_W-1:0] r_starve_cnt;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W-1:0]     r_cpu_rdata;
   logic [DATA_W-1:0]     r_ldr_rdata;

   logic w_any_req;
   logic w_pick_ldr;

   assign w_any_req  = cpu.req | ldr.req;
   assign w_pick_ldr = ldr.req & (~cpu.req | (r_starve_cnt == c_STARVE_MAX));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (w_any_req) w_next_state = S_ACCESS;
         S_ACCESS:  w_next_state = r_we ? S_IDLE : S_RD_WAIT;
         S_RD_WAIT: if (r_wait_cnt == 2'd0) w_next_state = S_RESP;
         S_RESP:    w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   // Access fields are frozen at the decision so requester changes afterwards are ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_owner_ldr  <= 1'b0;
         r_we         <= 1'b0;
         r_wait_cnt   <= 2'd0;
         r_starve_cnt <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_cpu_rdata  <= '0;
         r_ldr_rdata  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_owner_ldr <= w_pick_ldr;
                  r_we        <= w_pick_ldr ? ldr.we    : cpu.we;
                  r_addr      <= w_pick_ldr ? ldr.addr  : cpu.addr;
                  r_wdata     <= w_pick_ldr ? ldr.wdata : cpu.wdata;
               end
               if (!ldr.req || w_pick_ldr)
                  r_starve_cnt <= '0;
               else if (r_starve_cnt != c_STARVE_MAX)
                  r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            S_ACCESS: begin
               if (!r_we) r_wait_cnt <= c_WAIT_INIT;
            end
            S_RD_WAIT: begin
               if (r_wait_cnt != 2'd0)
                  r_wait_cnt <= r_wait_cnt - 2'd1;
               else if (r_owner_ldr)
                  r_ldr_rdata <= mem_rdata;
               else
                  r_cpu_rdata <= mem_rdata;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      cpu.gnt    = 1'b0;
      ldr.gnt    = 1'b0;
      cpu.rvalid = 1'b0;
      ldr.rvalid = 1'b0;
      mem_we     = 1'b0;
      busy       = (r_state != S_IDLE);
      if (r_state == S_ACCESS) begin
         mem_we  = r_we;
         cpu.gnt = ~r_owner_ldr;
         ldr.gnt = r_owner_ldr;
      end
      if (r_state == S_RESP) begin
         cpu.rvalid = ~r_owner_ldr;
         ldr.rvalid = r_owner_ldr;
      end
      cpu_stall = cpu.req & ~((cpu.gnt & r_we) | cpu.rvalid);
   end

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign cpu.rdata = r_cpu_rdata;
   assign ldr.rdata = r_ldr_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module : tb_mem_port_arbiter
//  Desc   : Directed bench for mem_port_arbiter (MEM_LAT=1/3, STARVE_LIMIT=2).
//  Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;
   localparam int AW = 8;
   localparam int DW = 32;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ldr_if ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu3_if ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ldr3_if ();

   logic          cpu_stall, mem_we, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          cpu_stall3, mem_we3, busy3;
   logic [AW-1:0] mem_addr3;
   logic [DW-1:0] mem_wdata3, mem_rdata3;

   logic [DW-1:0] mem1 [256];
   logic [DW-1:0] mem3 [256];
   logic [AW-1:0] apipe1 [3];
   logic [AW-1:0] apipe3 [3];

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_LIMIT(2)) dut (
      .clk(clk), .reset(reset), .cpu(cpu_if), .ldr(ldr_if), .cpu_stall(cpu_stall),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy));

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_LIMIT(2)) dut3 (
      .clk(clk), .reset(reset), .cpu(cpu3_if), .ldr(ldr3_if), .cpu_stall(cpu_stall3),
      .mem_addr(mem_addr3), .mem_we(mem_we3), .mem_wdata(mem_wdata3),
      .mem_rdata(mem_rdata3), .busy(busy3));

   // Memory models: read data appears MEM_LAT cycles after the address cycle.
   always @(posedge clk) begin
      if (mem_we)  mem1[mem_addr]  <= mem_wdata;
      if (mem_we3) mem3[mem_addr3] <= mem_wdata3;
      apipe1[0] <= mem_addr;  apipe1[1] <= apipe1[0]; apipe1[2] <= apipe1[1];
      apipe3[0] <= mem_addr3; apipe3[1] <= apipe3[0]; apipe3[2] <= apipe3[1];
   end
   assign mem_rdata  = mem1[apipe1[0]];
   assign mem_rdata3 = mem3[apipe3[2]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
      cpu_if.req  = 1'b1;
      cpu_if.we   = 1'b0;
      cpu_if.addr = a;
      lat = 0;
      d   = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk); #1;
         if (cpu_if.rvalid) begin
            lat = i;
            d   = cpu_if.rdata;
            break;
         end
      end
      cpu_if.req = 1'b0;
   endtask

   int            order [6];
   int            exp_order [6];
   int            n_gnt;
   int            lat;
   logic [DW-1:0] rd;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_order = '{0, 0, 1, 0, 0, 1};
      cpu_if.req = 0;  cpu_if.we = 0;  cpu_if.addr = 0;  cpu_if.wdata = 0;
      ldr_if.req = 0;  ldr_if.we = 0;  ldr_if.addr = 0;  ldr_if.wdata = 0;
      cpu3_if.req = 0; cpu3_if.we = 0; cpu3_if.addr = 0; cpu3_if.wdata = 0;
      ldr3_if.req = 0; ldr3_if.we = 0; ldr3_if.addr = 0; ldr3_if.wdata = 0;
      for (int i = 0; i < 256; i++) begin
         mem1[i] <= '0;
         mem3[i] <= '0;
      end
      mem1[8'h10] <= 32'hDEADBEEF;
      mem3[8'h20] <= 32'hCAFEF00D;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_cpu_gnt", cpu_if.gnt, 0);
      check("rst_ldr_rvalid", ldr_if.rvalid, 0);
      check("rst_cpu_rdata", cpu_if.rdata, 0);
      @(negedge clk) reset = 1'b1;

      // Reset in the middle of a read
      @(negedge clk);
      cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 8'h10;
      @(negedge clk); #1;
      check("t1_gnt", cpu_if.gnt, 1);
      @(negedge clk); #1;
      check("t1_rdwait_busy", busy, 1);
      reset = 1'b0;
      cpu_if.req = 0;
      #1;
      check("t1_busy", busy, 0);
      check("t1_mem_addr", mem_addr, 0);
      check("t1_stall", cpu_stall, 0);
      check("t1_rdata", cpu_if.rdata, 0);
      @(negedge clk); #1;
      check("t1_no_rvalid", cpu_if.rvalid, 0);
      reset = 1'b1;
      @(negedge clk); #1;
      check("t1_idle", busy, 0);
      check("t1_no_rvalid2", cpu_if.rvalid, 0);

      // CPU read of 0x10 with cycle-exact handshake
      @(negedge clk);
      cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 8'h10;
      #1;
      check("t2_stall_T", cpu_stall, 1);
      @(negedge clk); #1;
      check("t2_gnt_T1", cpu_if.gnt, 1);
      check("t2_addr_T1", mem_addr, 8'h10);
      check("t2_we_T1", mem_we, 0);
      check("t2_ldr_gnt", ldr_if.gnt, 0);
      check("t2_stall_T1", cpu_stall, 1);
      @(negedge clk); #1;
      check("t2_gnt_T2", cpu_if.gnt, 0);
      check("t2_rvalid_T2", cpu_if.rvalid, 0);
      check("t2_stall_T2", cpu_stall, 1);
      @(negedge clk); #1;
      check("t2_rvalid_T3", cpu_if.rvalid, 1);
      check("t2_rdata_T3", cpu_if.rdata, 32'hDEADBEEF);
      check("t2_stall_T3", cpu_stall, 0);
      cpu_if.req = 0;
      @(negedge clk); #1;
      check("t2_rvalid_T4", cpu_if.rvalid, 0);
      check("t2_rdata_hold", cpu_if.rdata, 32'hDEADBEEF);
      check("t2_idle", busy, 0);

      // CPU write: stall drops in the grant cycle
      cpu_if.req = 1; cpu_if.we = 1; cpu_if.addr = 8'h30; cpu_if.wdata = 32'h55AA;
      #1;
      check("tw_stall_T", cpu_stall, 1);
      @(negedge clk); #1;
      check("tw_gnt", cpu_if.gnt, 1);
      check("tw_mem_we", mem_we, 1);
      check("tw_wdata", mem_wdata, 32'h55AA);
      check("tw_stall_gnt", cpu_stall, 0);
      cpu_if.req = 0; cpu_if.we = 0;
      @(negedge clk); #1;
      check("tw_we_off", mem_we, 0);
      check("tw_addr_hold", mem_addr, 8'h30);
      check("tw_mem", mem1[8'h30], 32'h55AA);

      // Loader write then CPU read-back
      ldr_if.req = 1; ldr_if.we = 1; ldr_if.addr = 8'h05; ldr_if.wdata = 32'h1234;
      @(negedge clk); #1;
      check("t3_ldr_gnt", ldr_if.gnt, 1);
      check("t3_mem_we", mem_we, 1);
      check("t3_mem_addr", mem_addr, 8'h05);
      check("t3_cpu_gnt", cpu_if.gnt, 0);
      ldr_if.req = 0; ldr_if.we = 0;
      @(negedge clk);
      cpu_read(8'h05, rd, lat);
      check("t3_readback", rd, 32'h1234);
      check("t3_latency", lat, 3);

      // Simultaneous requests, starve_cnt=0: CPU first, loader on next decision
      @(negedge clk);
      cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 8'h10;
      ldr_if.req = 1; ldr_if.we = 0; ldr_if.addr = 8'h05;
      @(negedge clk); #1;
      check("t5_cpu_gnt", cpu_if.gnt, 1);
      check("t5_ldr_gnt0", ldr_if.gnt, 0);
      repeat (2) @(negedge clk);
      #1;
      check("t5_cpu_rvalid", cpu_if.rvalid, 1);
      check("t5_ldr_rvalid0", ldr_if.rvalid, 0);
      cpu_if.req = 0;
      @(negedge clk); #1;
      check("t5_idle", busy, 0);
      @(negedge clk); #1;
      check("t5_ldr_gnt", ldr_if.gnt, 1);
      repeat (2) @(negedge clk);
      #1;
      check("t5_ldr_rvalid", ldr_if.rvalid, 1);
      check("t5_ldr_rdata", ldr_if.rdata, 32'h1234);
      check("t5_cpu_rdata_hold", cpu_if.rdata, 32'hDEADBEEF);
      ldr_if.req = 0;
      @(negedge clk);

      // Both requesting continuously: C, C, L, C, C, L
      cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 8'h10;
      ldr_if.req = 1; ldr_if.we = 0; ldr_if.addr = 8'h05;
      n_gnt = 0;
      for (int i = 0; i < 60 && n_gnt < 6; i++) begin
         @(negedge clk); #1;
         if (cpu_if.gnt) begin
            order[n_gnt] = 0;
            n_gnt++;
         end else if (ldr_if.gnt) begin
            order[n_gnt] = 1;
            n_gnt++;
            check("t4_starve_clr", 32'(dut.r_starve_cnt), 0);
         end
      end
      cpu_if.req = 0;
      ldr_if.req = 0;
      check("t4_grant_count", n_gnt, 6);
      for (int i = 0; i < 6; i++)
         check($sformatf("t4_order_%0d", i), order[i], exp_order[i]);
      repeat (6) @(negedge clk);

      // MEM_LAT=3 read latency and data
      cpu3_if.req = 1; cpu3_if.we = 0; cpu3_if.addr = 8'h20;
      lat = 0;
      rd  = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk); #1;
         if (cpu3_if.rvalid) begin
            lat = i;
            rd  = cpu3_if.rdata;
            break;
         end
      end
      cpu3_if.req = 0;
      check("t6_latency", lat, 5);
      check("t6_rdata", rd, 32'hCAFEF00D);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
